// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one word read per PC, tagged result to decode
// Faults (misaligned, bus error, timeout) return NOP_INST with a cause code.
module ifu_fetch #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          CNT_W          = 8,
   parameter logic [31:0] NOP_INST       = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   input  logic        fetch_go,
   input  logic        flush,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   output logic        imem_resp_ready,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [31:0]      r_addr;
   logic [31:0]      r_inst;
   logic [31:0]      r_inst_pc;
   logic             r_fault;
   logic [1:0]       r_cause;
   logic             r_discard;
   logic [CNT_W-1:0] r_cnt;

   logic w_accept;
   logic w_disc;
   logic w_timeout;

   // A new PC is taken from IDLE, or from DONE in the same cycle decode consumes.
   assign w_accept  = fetch_go & ~flush &
                      ((r_state == S_IDLE) | ((r_state == S_DONE) & inst_ready));
   assign w_disc    = r_discard | flush;
   assign w_timeout = (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_inst    <= NOP_INST;
         r_inst_pc <= '0;
         r_fault   <= 1'b0;
         r_cause   <= 2'b00;
         r_discard <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_inst_pc <= fetch_pc;
                  if (fetch_pc[1:0] != 2'b00) begin
                     r_inst  <= NOP_INST;
                     r_fault <= 1'b1;
                     r_cause <= 2'b01;
                     r_state <= S_DONE;
                  end else begin
                     r_addr  <= fetch_pc;
                     r_state <= S_REQ;
                  end
               end else if ((r_state == S_DONE) && (flush || inst_ready)) begin
                  r_state <= S_IDLE;
               end
            end
            S_REQ: begin
               // The request stays on the bus until accepted; a flush only marks it stale.
               if (flush) r_discard <= 1'b1;
               if (imem_req_ready) begin
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid || w_timeout) begin
                  r_discard <= 1'b0;
                  r_cnt     <= '0;
                  if (w_disc) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_DONE;
                     if (imem_resp_valid) begin
                        r_inst  <= imem_resp_err ? NOP_INST : imem_resp_data;
                        r_fault <= imem_resp_err;
                        r_cause <= imem_resp_err ? 2'b10 : 2'b00;
                     end else begin
                        r_inst  <= NOP_INST;
                        r_fault <= 1'b1;
                        r_cause <= 2'b11;
                     end
                  end
               end else begin
                  r_discard <= w_disc;
                  r_cnt     <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_req_valid  = (r_state == S_REQ);
   assign imem_resp_ready = (r_state == S_WAIT);
   assign inst_valid      = (r_state == S_DONE);
   assign busy            = (r_state != S_IDLE);
   assign imem_req_addr   = r_addr;
   assign inst            = r_inst;
   assign inst_pc         = r_inst_pc;
   assign fault           = r_fault;
   assign fault_cause     = r_cause;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch against a fetch-level model
module tb_ifu_fetch;
   localparam int          TO  = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] fetch_pc = '0;
   logic        fetch_go = 1'b0;
   logic        flush = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic        imem_resp_ready;
   logic [31:0] imem_resp_data = '0;
   logic        imem_resp_err = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        busy;

   ifu_fetch #(.TIMEOUT_CYCLES(TO), .CNT_W(3), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_go(fetch_go), .flush(flush),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_ready(imem_resp_ready), .imem_resp_data(imem_resp_data),
      .imem_resp_err(imem_resp_err), .inst(inst), .inst_pc(inst_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .fault(fault),
      .fault_cause(fault_cause), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_acc = 0;

   // Model: a fetch is either waiting for the bus, in flight, or delivered to decode.
   bit          m_req, m_fly, m_out, m_disc;
   int          m_wait;
   logic [31:0] m_addr, m_pc, m_inst;
   bit          m_fault;
   logic [1:0]  m_cause;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_req = 0; m_fly = 0; m_out = 0; m_disc = 0; m_wait = 0;
   endtask

   task automatic deliver(input logic [31:0] i, input bit f, input logic [1:0] c);
      m_out = 1; m_inst = i; m_fault = f; m_cause = c;
   endtask

   task automatic start(input logic [31:0] pc);
      m_pc = pc;
      if (pc[1:0] != 2'b00) deliver(NOP, 1, 2'd1);
      else begin
         m_req = 1; m_addr = pc;
      end
   endtask

   task automatic model_next();
      bit disc;
      if (m_out) begin
         if (flush) m_out = 0;
         else if (inst_ready) begin
            m_out = 0;
            if (fetch_go) start(fetch_pc);
         end
      end else if (m_req) begin
         if (flush) m_disc = 1;
         if (imem_req_ready) begin
            m_req = 0; m_fly = 1; m_wait = 0;
         end
      end else if (m_fly) begin
         disc = m_disc || flush;
         if (imem_resp_valid || (m_wait + 1 == TO)) begin
            m_fly = 0; m_disc = 0;
            if (!disc) begin
               if (imem_resp_valid)
                  deliver(imem_resp_err ? NOP : imem_resp_data, imem_resp_err,
                          imem_resp_err ? 2'd2 : 2'd0);
               else
                  deliver(NOP, 1, 2'd3);
            end
         end else begin
            m_wait++; m_disc = disc;
         end
      end else if (fetch_go && !flush) begin
         start(fetch_pc);
      end
   endtask

   task automatic compare();
      chk("req_valid", imem_req_valid, m_req);
      chk("resp_ready", imem_resp_ready, m_fly);
      chk("inst_valid", inst_valid, m_out);
      chk("busy", busy, m_req | m_fly | m_out);
      if (m_req) chk("req_addr", imem_req_addr, m_addr);
      if (m_out) begin
         chk("inst", inst, m_inst);
         chk("inst_pc", inst_pc, m_pc);
         chk("fault", fault, m_fault);
         chk("fault_cause", fault_cause, m_cause);
      end
   endtask

   task automatic step(input bit go, input logic [31:0] pc, input bit fl, input bit rqr,
                       input bit rv, input logic [31:0] rd, input bit re, input bit ir);
      fetch_go = go; fetch_pc = pc; flush = fl; imem_req_ready = rqr;
      imem_resp_valid = rv; imem_resp_data = rd; imem_resp_err = re; inst_ready = ir;
      if (imem_req_valid && imem_req_ready) n_acc++;
      model_next();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic chk_reset_vals();
      chk("rst req_valid", imem_req_valid, 0);
      chk("rst resp_ready", imem_resp_ready, 0);
      chk("rst inst_valid", inst_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst fault", fault, 0);
      chk("rst inst", inst, NOP);
      chk("rst inst_pc", inst_pc, 0);
      chk("rst req_addr", imem_req_addr, 0);
      chk("rst cause", fault_cause, 0);
   endtask

   initial begin
      int          a0;
      int          delay;
      logic [31:0] pc;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals();
      rst = 1'b0;
      model_reset();

      // Basic fetch with the minimum latency
      step(1, 32'h80000000, 0, 1, 0, 0, 0, 0);
      chk("basic req_valid c1", imem_req_valid, 1);
      chk("basic addr c1", imem_req_addr, 32'h80000000);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      chk("basic resp_ready c2", imem_resp_ready, 1);
      step(0, 0, 0, 0, 1, 32'h00100093, 0, 0);
      chk("basic inst_valid c3", inst_valid, 1);
      chk("basic inst", inst, 32'h00100093);
      chk("basic inst_pc", inst_pc, 32'h80000000);
      chk("basic fault", fault, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);

      // Backpressure on both sides
      a0 = n_acc;
      step(1, 32'h80000010, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0);
         chk("bp req_valid held", imem_req_valid, 1);
         chk("bp addr held", imem_req_addr, 32'h80000010);
      end
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h12345678, 0, 0);
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0);
         chk("bp inst held", inst, 32'h12345678);
         chk("bp inst_valid held", inst_valid, 1);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("bp single request", n_acc - a0, 1);

      // Misaligned PC faults without touching the bus
      step(1, 32'h80000002, 0, 1, 0, 0, 0, 0);
      chk("mis req_valid", imem_req_valid, 0);
      chk("mis inst_valid", inst_valid, 1);
      chk("mis inst", inst, 32'h00000013);
      chk("mis cause", fault_cause, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);

      // Bus error
      step(1, 32'h80000020, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'hAAAAAAAA, 1, 0);
      chk("err cause", fault_cause, 2);
      chk("err inst", inst, 32'h00000013);
      chk("err fault", fault, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);

      // Timeout after exactly TO wait cycles
      step(1, 32'h80000030, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < TO - 1; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("to still waiting", imem_resp_ready, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("to inst_valid", inst_valid, 1);
      chk("to cause", fault_cause, 3);
      chk("to inst", inst, 32'h00000013);
      step(0, 0, 0, 0, 0, 0, 0, 1);

      // Flush while waiting drops the response, next fetch is clean
      step(1, 32'h80000040, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
      chk("flush idle", busy, 0);
      chk("flush no inst", inst_valid, 0);
      step(1, 32'h80000004, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h00200113, 0, 0);
      chk("post flush inst", inst, 32'h00200113);
      chk("post flush pc", inst_pc, 32'h80000004);
      step(0, 0, 0, 0, 0, 0, 0, 1);

      // Back-to-back: consume and take the next PC in the same cycle
      pc = 32'h80000100;
      step(1, pc, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 1, 0, 0, 0, 0);
         step(0, 0, 0, 0, 1, 32'h00a00093 + k, 0, 0);
         chk("b2b inst", inst, 32'h00a00093 + k);
         chk("b2b inst_pc", inst_pc, pc);
         pc = pc + 4;
         step(k < 2, pc, 0, 0, 0, 0, 0, 1);
         if (k < 2) begin
            chk("b2b busy", busy, 1);
            chk("b2b next addr", imem_req_addr, pc);
         end
      end

      // Asynchronous reset while waiting
      step(1, 32'h80000200, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      chk("pre-rst waiting", imem_resp_ready, 1);
      rst = 1'b1;
      #1;
      chk_reset_vals();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomised traffic; memory answers after 0..TO+1 cycles (>= TO never answers)
      delay = 0;
      for (int c = 0; c < 3000; c++) begin
         bit          go, fl, rqr, rv, re, ir;
         logic [31:0] rpc, rd;
         if (m_fly && m_wait == 0) delay = $urandom_range(0, TO + 1);
         go  = ($urandom_range(0, 3) != 0);
         rpc = $urandom;
         if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
         fl  = ($urandom_range(0, 11) == 0);
         rqr = ($urandom_range(0, 1) == 1);
         rv  = m_fly ? (m_wait == delay) : ($urandom_range(0, 7) == 0);
         rd  = $urandom;
         re  = ($urandom_range(0, 4) == 0);
         ir  = ($urandom_range(0, 2) != 0);
         step(go, rpc, fl, rqr, rv, rd, re, ir);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
